// File: rtl/and3_or3.sv
// Bitwise 3-input AND/OR with a combinational path and a valid-qualified registered path.
// WIDTH independent gates share one instance.
module and3_or3 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] and_o,
  output logic [WIDTH-1:0] or_o,
  output logic [WIDTH-1:0] and_q,
  output logic [WIDTH-1:0] or_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] and_d;
  logic [WIDTH-1:0] or_d;
  logic             valid_d;

  // Plain operators keep the X/Z dominance rules of the built-in gates.
  assign and_o = i1 & i2 & i3;
  assign or_o  = i1 | i2 | i3;

  always_comb begin
    and_d   = and_q;
    or_d    = or_q;
    valid_d = in_valid;
    if (in_valid) begin
      and_d = and_o;
      or_d  = or_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_q     <= '0;
      or_q      <= '0;
      out_valid <= 1'b0;
    end else begin
      and_q     <= and_d;
      or_q      <= or_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_and3_or3.sv
// Directed bench for and3_or3: table-driven truth-table sweep plus registered-path sequences.
module tb_and3_or3;

  typedef struct {
    logic [2:0] in;     // {i3,i2,i1}
    logic       and_e;
    logic       or_e;
  } vec1_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] and_e;
    logic [3:0] or_e;
  } vec4_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [0:0] a1, b1, c1, and_o1, or_o1, and_q1, or_q1;
  logic       out_valid1;
  logic [3:0] a4, b4, c4, and_o4, or_o4, and_q4, or_q4;
  logic       out_valid4;

  int checks;
  int failures;

  vec1_t tv1[8];
  vec4_t tv4[3];

  and3_or3 #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .i1       (a1),
    .i2       (b1),
    .i3       (c1),
    .and_o    (and_o1),
    .or_o     (or_o1),
    .and_q    (and_q1),
    .or_q     (or_q1),
    .out_valid(out_valid1)
  );

  and3_or3 #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .i1       (a4),
    .i2       (b4),
    .i3       (c4),
    .and_o    (and_o4),
    .or_o     (or_o4),
    .and_q    (and_q4),
    .or_q     (or_q4),
    .out_valid(out_valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive1(input logic [2:0] v);
    {c1, b1, a1} = v;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    tv1[0] = '{3'b000, 1'b0, 1'b0};
    tv1[1] = '{3'b001, 1'b0, 1'b1};
    tv1[2] = '{3'b010, 1'b0, 1'b1};
    tv1[3] = '{3'b011, 1'b0, 1'b1};
    tv1[4] = '{3'b100, 1'b0, 1'b1};
    tv1[5] = '{3'b101, 1'b0, 1'b1};
    tv1[6] = '{3'b110, 1'b0, 1'b1};
    tv1[7] = '{3'b111, 1'b1, 1'b1};

    tv4[0] = '{4'b1100, 4'b1010, 4'b1001, 4'b1000, 4'b1111};
    tv4[1] = '{4'b1111, 4'b1111, 4'b0111, 4'b0111, 4'b1111};
    tv4[2] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0011};

    // Reset state; combinational path must work while in reset.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    drive1(3'b111);
    a4 = 4'b0; b4 = 4'b0; c4 = 4'b0;
    #3;
    check("reset_and_q1", {3'b0, and_q1}, 4'b0);
    check("reset_or_q1", {3'b0, or_q1}, 4'b0);
    check("reset_valid1", {3'b0, out_valid1}, 4'b0);
    check("reset_and_q4", and_q4, 4'b0);
    check("reset_comb_and1", {3'b0, and_o1}, 4'b1);
    @(posedge clk); #1;
    check("reset_hold_valid1", {3'b0, out_valid1}, 4'b0);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Exhaustive truth table, 100 ps... scaled to 1 time unit per step.
    for (int i = 0; i < 8; i++) begin
      drive1(tv1[i].in);
      #1;
      check($sformatf("and_o1[%0d]", i), {3'b0, and_o1}, {3'b0, tv1[i].and_e});
      check($sformatf("or_o1[%0d]", i), {3'b0, or_o1}, {3'b0, tv1[i].or_e});
    end

    for (int i = 0; i < 3; i++) begin
      a4 = tv4[i].a; b4 = tv4[i].b; c4 = tv4[i].c;
      #1;
      check($sformatf("and_o4[%0d]", i), and_o4, tv4[i].and_e);
      check($sformatf("or_o4[%0d]", i), or_o4, tv4[i].or_e);
    end

    // Registered path: 111 then 000 back to back.
    @(negedge clk);
    in_valid = 1'b1;
    drive1(3'b111);
    a4 = 4'b1100; b4 = 4'b1010; c4 = 4'b1001;
    @(posedge clk); #1;
    check("reg111_and_q", {3'b0, and_q1}, 4'b1);
    check("reg111_or_q", {3'b0, or_q1}, 4'b1);
    check("reg111_valid", {3'b0, out_valid1}, 4'b1);
    check("reg4_and_q", and_q4, 4'b1000);
    check("reg4_or_q", or_q4, 4'b1111);
    @(negedge clk);
    drive1(3'b000);
    @(posedge clk); #1;
    check("reg000_and_q", {3'b0, and_q1}, 4'b0);
    check("reg000_or_q", {3'b0, or_q1}, 4'b0);
    check("reg000_valid", {3'b0, out_valid1}, 4'b1);

    // Hold: capture 111, then in_valid=0 with 000.
    @(negedge clk);
    drive1(3'b111);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    drive1(3'b000);
    @(posedge clk); #1;
    check("hold_and_q", {3'b0, and_q1}, 4'b1);
    check("hold_or_q", {3'b0, or_q1}, 4'b1);
    check("hold_valid", {3'b0, out_valid1}, 4'b0);
    check("hold_and_q4", and_q4, 4'b1000);

    // Make out_valid=1 again, then reset between edges.
    @(negedge clk);
    in_valid = 1'b1;
    drive1(3'b111);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_and_q", {3'b0, and_q1}, 4'b0);
    check("async_or_q", {3'b0, or_q1}, 4'b0);
    check("async_valid", {3'b0, out_valid1}, 4'b0);
    check("async_or_q4", or_q4, 4'b0);
    drive1(3'b001);
    #1;
    check("async_comb_and", {3'b0, and_o1}, 4'b0);
    check("async_comb_or", {3'b0, or_o1}, 4'b1);
    drive1(3'b111);
    @(posedge clk); #1;
    check("in_reset_and_q", {3'b0, and_q1}, 4'b0);
    check("in_reset_valid", {3'b0, out_valid1}, 4'b0);

    // First capture after release.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_and_q", {3'b0, and_q1}, 4'b1);
    check("post_reset_valid", {3'b0, out_valid1}, 4'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/and3_or3.md
# and3_or3

Three-input AND/OR gate unit providing both the AND3 and OR3 functions on a shared input set. Both functions have a combinational output path and a registered output path. The block is a leaf primitive used wherever a 3-input reduction is needed, either directly in combinational logic or aligned to the system clock. Each of the three inputs is WIDTH bits wide, and the gates are applied bitwise, so WIDTH independent 3-input gates share one instance.

## Interface
- WIDTH, default 1: bit width of each input and output; values of 1 or more are legal.
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies i1/i2/i3 for the registered path.
- i1  input  WIDTH  gate input 1.
- i2  input  WIDTH  gate input 2.
- i3  input  WIDTH  gate input 3.
- and_o  output  WIDTH  combinational AND3: i1 & i2 & i3.
- or_o  output  WIDTH  combinational OR3: i1 | i2 | i3.
- and_q  output  WIDTH  registered AND3 result.
- or_q  output  WIDTH  registered OR3 result.
- out_valid  output  1  registered qualifier for and_q and or_q.

## Operation
- Combinational path:
  - and_o[k] = i1[k] & i2[k] & i3[k] for every bit k.
  - or_o[k] = i1[k] | i2[k] | i3[k] for every bit k.
  - No dependence on clk or rst_n; the outputs are valid even while reset is asserted.
- Truth table per bit, for inputs {i3,i2,i1} = 000..111:
  - and_o = 0,0,0,0,0,0,0,1.
  - or_o = 0,1,1,1,1,1,1,1.
- Registered path:
  - On a rising clk edge with in_valid=1, and_q/or_q capture the current and_o/or_o values, and out_valid goes to 1.
  - On a rising clk edge with in_valid=0, and_q/or_q hold their previous values, and out_valid goes to 0.
- X/Z handling: the combinational path follows standard Verilog gate semantics.
  - A 0 on any input forces and_o to 0.
  - A 1 on any input forces or_o to 1.
- No internal state other than the three output registers.

## Timing
- Combinational path: zero-cycle latency; settles within one gate delay of an input change.
- Registered path: exactly 1-cycle latency from an in_valid=1 sample to the updated and_q/or_q and out_valid=1.
- Throughput: one result per cycle; back-to-back in_valid=1 updates the outputs every cycle.
- Reset behaviour:
  - Asserting rst_n=0 immediately (asynchronously) clears and_q=0, or_q=0 and out_valid=0, independent of clk.
  - The registered outputs stay cleared while rst_n=0.
  - Deassertion is synchronous to the next rising edge: the first capture happens on the first rising edge with rst_n=1 and in_valid=1.
- Reset asserted mid-stream discards the in-flight result; no partial or stale result is presented after reset.
- Simultaneous input change and clock edge: the registered path samples the values present before the edge (standard setup/hold applies).

## Test plan
- Exhaustive AND3, WIDTH=1: step {i3,i2,i1} through 000..111, holding each value for 100 ps.
  - Required: and_o=1 only at 111 and 0 for every other value.
- Exhaustive OR3, WIDTH=1: the same 000..111 sweep.
  - Required: or_o=0 only at 000 and 1 for every other value.
- Registered path:
  - With in_valid=1, drive 111 and then 000 on successive cycles.
  - Required: one cycle later, and_q=1 and or_q=1; the following cycle, and_q=0 and or_q=0; out_valid=1 throughout.
- Hold behaviour:
  - Capture 111, then drop in_valid to 0 and drive 000.
  - Required: and_q/or_q hold at 1 and out_valid=0 on the next edge.
- Asynchronous reset:
  - Assert rst_n=0 between clock edges while and_q=1.
  - Required: and_q, or_q and out_valid go to 0 immediately; and_o/or_o still track the inputs.
- Bitwise operation, WIDTH=4:
  - Drive i1=4'b1100, i2=4'b1010, i3=4'b1001.
  - Required: and_o=4'b1000 and or_o=4'b1111.
